carry_look_ahead_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 23 ++
 rtl/cla4_block.sv | 23 ++
 rtl/carry_look_ahead_adder.sv | 87 ++++++++
 tb/tb_carry_look_ahead_adder.sv | 81 ++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared group width, group generate/propagate type and 4-bit lookahead helpers.
package cla_pkg;
    localparam int GROUP_W = 4;
    typedef struct packed {
        logic gg;
        logic gp;
    } gp_pair_t;
    // Every carry is a flat sum of products of g, p and c0; nothing ripples inside a group.
    function automatic logic [GROUP_W-1:0] group_carry(input logic [GROUP_W-1:0] g, input logic [GROUP_W-1:0] p, input logic c0);
        logic [GROUP_W-1:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction
    function automatic gp_pair_t group_gp(input logic [GROUP_W-1:0] g, input logic [GROUP_W-1:0] p);
        gp_pair_t r;
        r.gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        r.gp = &p;
        return r;
    endfunction
endpackage

// File: rtl/cla4_block.sv
// cla4_block: combinational 4-bit lookahead group producing sum bits and group generate/propagate.
module cla4_block
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               c0,
    output logic [GROUP_W-1:0] s,
    output logic               gg,
    output logic               gp
);
    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_c;
    gp_pair_t           w_grp;
    assign w_g   = a & b;
    assign w_p   = a ^ b;
    assign w_c   = group_carry(w_g, w_p, c0);
    assign s     = w_p ^ w_c;
    assign w_grp = group_gp(w_g, w_p);
    assign gg    = w_grp.gg;
    assign gp    = w_grp.gp;
endmodule

// File: rtl/carry_look_ahead_adder.sv
// carry_look_ahead_adder: registered two-level carry-lookahead adder, {Cout,S} = A + B + Cin.
// Define CLA_IN_REG_EN to register A/B/Cin ahead of the lookahead logic (latency 2 instead of 1).
module carry_look_ahead_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);
    localparam int NG = WIDTH / GROUP_W;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_cin;
    logic [WIDTH-1:0] w_s;
    logic [NG-1:0]    w_gg;
    logic [NG-1:0]    w_gp;
    logic [NG:0]      w_gen;
    logic [NG:0]      w_c;
    logic             w_t;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
`ifdef CLA_IN_REG_EN
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= 1'b0;
        end else begin
            r_a   <= A;
            r_b   <= B;
            r_cin <= Cin;
        end
    end
    assign w_a   = r_a;
    assign w_b   = r_b;
    assign w_cin = r_cin;
`else
    assign w_a   = A;
    assign w_b   = B;
    assign w_cin = Cin;
`endif
    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla4_block u_blk (
            .a  (w_a[k*GROUP_W +: GROUP_W]),
            .b  (w_b[k*GROUP_W +: GROUP_W]),
            .c0 (w_c[k]),
            .s  (w_s[k*GROUP_W +: GROUP_W]),
            .gg (w_gg[k]),
            .gp (w_gp[k])
        );
    end
    // Generator index 0 is Cin, index j>0 is GG[j-1]; each group carry ORs every generator
    // ANDed with the propagates between it and that group, so no carry depends on another.
    assign w_gen = {w_gg, w_cin};
    always_comb begin
        w_c    = '0;
        w_t    = 1'b0;
        w_c[0] = w_cin;
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j <= k + 1; j++) begin
                w_t = w_gen[j];
                for (int m = j; m <= k; m++) w_t = w_t & w_gp[m];
                w_c[k+1] = w_c[k+1] | w_t;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_s;
            r_cout <= w_c[NG];
        end
    end
    assign S    = r_s;
    assign Cout = r_cout;
endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// tb_carry_look_ahead_adder: directed vectors through 4-bit and 16-bit instances, streamed one per cycle.
module tb_carry_look_ahead_adder;
`ifdef CLA_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int N = 8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  a4 = '0, b4 = '0, s4;
    logic        cin4 = 1'b0, cout4;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        cin16 = 1'b0, cout16;
    int          n_checks = 0;
    int          n_errs = 0;
    logic [3:0]  ta4 [N] = '{4'h1, 4'h2, 4'hB, 4'h5, 4'hF, 4'h0, 4'hF, 4'h7};
    logic [3:0]  tb4 [N] = '{4'h0, 4'h4, 4'h6, 4'h3, 4'hF, 4'h0, 4'h0, 4'h8};
    logic        tc4 [N] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0]  te4 [N] = '{5'd1, 5'd7, 5'd17, 5'd9, 5'd31, 5'd0, 5'd16, 5'd15};
    logic [15:0] ta16 [N] = '{16'hFFFF, 16'h00FF, 16'h8000, 16'h1234, 16'hFFFF, 16'h0000, 16'h0F0F, 16'hABCD};
    logic [15:0] tb16 [N] = '{16'h0000, 16'h0001, 16'h8000, 16'h4321, 16'hFFFF, 16'h0000, 16'hF0F0, 16'h1111};
    logic        tc16 [N] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [16:0] te16 [N] = '{17'h10000, 17'h00100, 17'h10000, 17'h05555, 17'h1FFFF, 17'h00000, 17'h10000, 17'h0BCDF};
    always #5 clk = ~clk;
    carry_look_ahead_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4), .S(s4), .Cout(cout4)
    );
    carry_look_ahead_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(cin16), .S(s16), .Cout(cout16)
    );
    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic run_stream(input string pass);
        for (int k = 0; k < N + LAT; k++) begin
            @(negedge clk);
            if (k >= LAT) begin
                check($sformatf("%s_w4_v%0d", pass, k - LAT), {12'b0, cout4, s4}, {12'b0, te4[k-LAT]});
                check($sformatf("%s_w16_v%0d", pass, k - LAT), {cout16, s16}, te16[k-LAT]);
            end
            if (k < N) begin
                a4 = ta4[k]; b4 = tb4[k]; cin4 = tc4[k];
                a16 = ta16[k]; b16 = tb16[k]; cin16 = tc16[k];
            end
        end
    endtask
    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset_w4", {12'b0, cout4, s4}, 17'h0);
        check("reset_w16", {cout16, s16}, 17'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_stream("s1");
        @(negedge clk);
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
        repeat (LAT) @(posedge clk);
        #2;
        check("pre_rst_w4", {12'b0, cout4, s4}, 17'h0001F);
        check("pre_rst_w16", {cout16, s16}, 17'h1FFFF);
        rst_n = 1'b0;
        #1;
        check("async_rst_w4", {12'b0, cout4, s4}, 17'h0);
        check("async_rst_w16", {cout16, s16}, 17'h0);
        @(posedge clk);
        #1;
        check("held_rst_w4", {12'b0, cout4, s4}, 17'h0);
        check("held_rst_w16", {cout16, s16}, 17'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_stream("s2");
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
